// File: rtl/arith_chain_arbiter.sv
// arith_chain_arbiter: round-robin scheduler sharing one non-pipelined arithmetic-chain engine
module arith_chain_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH_IN  = 8,
    parameter int DATA_WIDTH_OUT = 10,
    parameter int ENGINE_LATENCY = 4,
    parameter int TIMEOUT        = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*DATA_WIDTH_IN-1:0]   req_data,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic [DATA_WIDTH_IN-1:0]           eng_data_in,
    output logic                               eng_valid_in,
    input  logic [DATA_WIDTH_OUT-1:0]          eng_data_out,
    input  logic                               eng_valid_out,
    output logic                               rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]         rsp_id,
    output logic [DATA_WIDTH_OUT-1:0]          rsp_data,
    output logic                               busy,
    output logic                               timeout_err,
    output logic                               spurious_err
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {FLUSH, IDLE, ISSUE, WAIT} state_t;

    state_t                   state, state_n;
    logic [CW-1:0]            cnt;
    logic [IW-1:0]            last_grant, tag, winner;
    logic                     found, accept;
    logic [DATA_WIDTH_IN-1:0] ops [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_ops
        assign ops[i] = req_data[i*DATA_WIDTH_IN +: DATA_WIDTH_IN];
    end

    // round-robin search starting just after the last granted requester
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req_valid[IW'((int'(last_grant) + k) % NUM_REQ)]) begin
                found  = 1'b1;
                winner = IW'((int'(last_grant) + k) % NUM_REQ);
            end
        end
    end

    assign accept       = state == IDLE && found;
    assign req_ready    = accept ? NUM_REQ'(1) << winner : '0;
    assign eng_valid_in = state == ISSUE;
    assign busy         = state != IDLE;

    // next state: flush drains a job left in flight, wait ends on result or timeout
    always_comb begin
        state_n = state;
        unique case (state)
            FLUSH:   state_n = cnt == CW'(ENGINE_LATENCY) ? IDLE : FLUSH;
            IDLE:    state_n = accept ? ISSUE : IDLE;
            ISSUE:   state_n = WAIT;
            WAIT:    state_n = (eng_valid_out || cnt == CW'(TIMEOUT)) ? IDLE : WAIT;
            default: state_n = FLUSH;
        endcase
    end

    // state, counters, issued job, response capture and sticky error flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= FLUSH;
            cnt          <= '0;
            last_grant   <= IW'(NUM_REQ - 1);
            tag          <= '0;
            eng_data_in  <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_data     <= '0;
            timeout_err  <= 1'b0;
            spurious_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= state == ISSUE ? CW'(1) : cnt + CW'(1);
            rsp_valid <= 1'b0;
            if (accept) begin
                eng_data_in <= ops[winner];
                tag         <= winner;
                last_grant  <= winner;
            end
            if (state == WAIT && eng_valid_out) begin
                rsp_valid <= 1'b1;
                rsp_id    <= tag;
                rsp_data  <= eng_data_out;
            end
            if (state == WAIT && !eng_valid_out && cnt == CW'(TIMEOUT))
                timeout_err <= 1'b1;
            if ((state == IDLE || state == ISSUE) && eng_valid_out)
                spurious_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_arith_chain_arbiter.sv
// tb_arith_chain_arbiter: scoreboard bench with an engine stub (+5, -3, +10, 4-cycle latency)
module tb_arith_chain_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic [7:0]  eng_data_in;
    logic        eng_valid_in;
    logic [9:0]  eng_data_out;
    logic        eng_valid_out;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [9:0]  rsp_data;
    logic        busy, timeout_err, spurious_err;

    typedef struct {logic [1:0] id; logic [9:0] data; int cyc;} exp_t;
    exp_t sb[$];
    exp_t e;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;

    logic [9:0] e_data = '0;
    int         e_cnt = 0;
    logic       e_out = 1'b0;
    logic       mute = 1'b0;
    logic       force_vo = 1'b0;

    arith_chain_arbiter dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .eng_data_in(eng_data_in), .eng_valid_in(eng_valid_in), .eng_data_out(eng_data_out),
        .eng_valid_out(eng_valid_out), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .busy(busy), .timeout_err(timeout_err), .spurious_err(spurious_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // engine stub: not reset with the DUT, drops jobs offered while busy
    always @(posedge clk) begin
        if (e_cnt == 1) begin
            e_out <= 1'b1;
            e_cnt <= 0;
        end else begin
            e_out <= 1'b0;
            if (e_cnt > 1) e_cnt <= e_cnt - 1;
        end
        if (eng_valid_in && e_cnt == 0) begin
            e_cnt  <= 3;
            e_data <= 10'(eng_data_in) + 10'd5 - 10'd3 + 10'd10;
        end
    end

    assign eng_valid_out = (e_out & ~mute) | force_vo;
    assign eng_data_out  = e_data;

    // response monitor: every rsp_valid cycle must match the oldest expectation
    always @(negedge clk) begin
        if (rsp_valid) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL rsp_unexpected: got id=%0d data=%0d at cycle %0d, required no response", rsp_id, rsp_data, cyc);
            end else begin
                e = sb.pop_front();
                if (rsp_id !== e.id || rsp_data !== e.data || busy !== 1'b0 || cyc != e.cyc) begin
                    n_err++;
                    $display("FAIL rsp: got id=%0d data=%0d busy=%b cycle=%0d, required id=%0d data=%0d busy=0 cycle=%0d",
                             rsp_id, rsp_data, busy, cyc, e.id, e.data, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input int i, input logic [7:0] d);
        req_valid[i] = 1'b1;
        req_data[i*8 +: 8] = d;
    endtask

    task automatic push_exp(input int i);
        sb.push_back('{id: 2'(i), data: 10'(req_data[i*8 +: 8]) + 10'd12, cyc: cyc + 6});
    endtask

    task automatic wait_grant(output int waited);
        waited = 0;
        #1;
        while (req_ready == 4'b0 && waited < 40) begin
            @(negedge clk);
            #1;
            waited++;
        end
    endtask

    task automatic expect_grant(input int i, input string name);
        int w;
        wait_grant(w);
        n_vec++;
        if (req_ready !== 4'(1 << i)) begin
            n_err++;
            $display("FAIL %s: req_ready got %b required %b", name, req_ready, 4'(1 << i));
        end
        push_exp(i);
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic drain;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset;
        do_reset();
        n_vec++;
        if ({req_ready, eng_valid_in, eng_data_in, rsp_valid, rsp_id, rsp_data} !== 27'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h required 0", {req_ready, eng_valid_in, eng_data_in, rsp_valid, rsp_id, rsp_data});
        end
        n_vec++;
        if ({timeout_err, spurious_err, busy} !== 3'b001) begin
            n_err++;
            $display("FAIL reset_flags: got te/se/busy=%b required 001", {timeout_err, spurious_err, busy});
        end
    endtask

    task automatic test_first_grant;
        int w;
        reset = 1'b0;
        set_req(0, 8'd20);
        wait_grant(w);
        n_vec++;
        if (w != 5 || req_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL first_grant: got cycle %0d ready %b required cycle 5 ready 0001", w, req_ready);
        end
        push_exp(0);
        @(negedge clk);
        req_valid = '0;
        n_vec++;
        if (eng_valid_in !== 1'b1 || eng_data_in !== 8'd20 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL issue: got vin=%b din=%0d busy=%b required 1 20 1", eng_valid_in, eng_data_in, busy);
        end
        @(negedge clk);
        n_vec++;
        if (eng_valid_in !== 1'b0 || eng_data_in !== 8'd20) begin
            n_err++;
            $display("FAIL issue_end: got vin=%b din=%0d required 0 20", eng_valid_in, eng_data_in);
        end
        drain();
    endtask

    task automatic test_round_robin;
        int prev;
        do_reset();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 8'(i + 1));
        prev = 0;
        for (int n = 0; n < 4; n++) begin
            expect_grant(n, "rr_grant");
            if (n > 0) begin
                n_vec++;
                if (cyc - prev != 6) begin
                    n_err++;
                    $display("FAIL rr_spacing: got %0d cycles required 6", cyc - prev);
                end
            end
            prev = cyc;
            @(negedge clk);
        end
        req_valid = '0;
        drain();
    endtask

    task automatic test_contention;
        @(negedge clk);
        set_req(2, 8'd255);
        expect_grant(2, "rr_single");
        @(negedge clk);
        set_req(0, 8'd50);
        expect_grant(0, "rr_after_2");
        @(negedge clk);
        req_valid[0] = 1'b0;
        expect_grant(2, "rr_then_2");
        @(negedge clk);
        req_valid = '0;
        drain();
    endtask

    task automatic test_timeout;
        int c;
        mute = 1'b1;
        @(negedge clk);
        set_req(1, 8'd9);
        wait_grant(c);
        n_vec++;
        if (req_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL to_grant: req_ready got %b required 0010", req_ready);
        end
        c = cyc;
        @(negedge clk);
        req_valid = '0;
        while (cyc < c + 9) @(negedge clk);
        n_vec++;
        if (timeout_err !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL to_early: got te=%b busy=%b required 0 1", timeout_err, busy);
        end
        @(negedge clk);
        n_vec++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL to_flag: got te=%b busy=%b required 1 0", timeout_err, busy);
        end
        mute = 1'b0;
        set_req(3, 8'd100);
        expect_grant(3, "to_next_grant");
        @(negedge clk);
        req_valid = '0;
        drain();
        n_vec++;
        if (timeout_err !== 1'b1) begin
            n_err++;
            $display("FAIL to_sticky: got %b required 1", timeout_err);
        end
    endtask

    task automatic test_spurious;
        @(negedge clk);
        n_vec++;
        if (spurious_err !== 1'b0) begin
            n_err++;
            $display("FAIL sp_pre: got %b required 0", spurious_err);
        end
        force_vo = 1'b1;
        @(negedge clk);
        force_vo = 1'b0;
        n_vec++;
        if (spurious_err !== 1'b1) begin
            n_err++;
            $display("FAIL sp_flag: got %b required 1", spurious_err);
        end
        repeat (10) @(negedge clk);
        n_vec++;
        if (spurious_err !== 1'b1) begin
            n_err++;
            $display("FAIL sp_sticky: got %b required 1", spurious_err);
        end
    endtask

    task automatic test_reset_mid_wait;
        int c;
        do_reset();
        n_vec++;
        if ({timeout_err, spurious_err} !== 2'b00) begin
            n_err++;
            $display("FAIL rst_clear: got te/se=%b required 00", {timeout_err, spurious_err});
        end
        reset = 1'b0;
        set_req(1, 8'd40);
        wait_grant(c);
        n_vec++;
        if (req_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL rw_grant: req_ready got %b required 0010", req_ready);
        end
        c = cyc;
        @(negedge clk);
        req_valid = '0;
        while (cyc < c + 3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_vec++;
            if (busy !== 1'b1) begin
                n_err++;
                $display("FAIL rw_flush_busy: cycle %0d busy got %b required 1", k, busy);
            end
            @(negedge clk);
        end
        n_vec++;
        if (busy !== 1'b0 || spurious_err !== 1'b0) begin
            n_err++;
            $display("FAIL rw_after_flush: got busy=%b se=%b required 0 0", busy, spurious_err);
        end
        set_req(0, 8'd60);
        set_req(2, 8'd70);
        expect_grant(0, "rw_first_grant");
        @(negedge clk);
        req_valid[0] = 1'b0;
        expect_grant(2, "rw_second_grant");
        @(negedge clk);
        req_valid = '0;
        drain();
    endtask

    initial begin
        test_reset();
        test_first_grant();
        test_round_robin();
        test_contention();
        test_timeout();
        test_spurious();
        test_reset_mid_wait();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL pending_responses: got %0d outstanding required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
